// File: rtl/psum_readout_ctrl_pkg.sv
// Shared definitions for the partial-sum SRAM read-out path:
// pmem geometry, SRAM read latency and the read-controller FSM states.
package psum_readout_ctrl_pkg;

  localparam int unsigned PMEM_WORDS   = 2048;
  localparam int unsigned PMEM_ADDR_BW = $clog2(PMEM_WORDS);
  localparam int unsigned RD_LAT       = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/psum_skid_fifo.sv
// 2-entry synchronous FIFO, width-parameterized.
// Ports: clk, reset (async, active high), push/pop requests, data_in,
//        head_c (current head entry, read from storage registers),
//        count (registered occupancy), full_c / empty_c flags.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module psum_skid_fifo #(
  parameter int unsigned width = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] data_in,
  output logic [width-1:0] head_c,
  output logic [1:0]       count,
  output logic             full_c,
  output logic             empty_c
);

  logic [width-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push_c;
  logic             do_pop_c;

  assign empty_c   = (count == 2'd0);
  assign full_c    = (count == 2'd2);
  assign do_pop_c  = pop & ~empty_c;
  assign do_push_c = push & (~full_c | do_pop_c);
  assign head_c    = mem[rd_ptr];

  // Pointers and occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push_c) wr_ptr <= ~wr_ptr;
      if (do_pop_c)  rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push_c) - 2'(do_pop_c);
    end
  end

  // Storage, no reset needed: entries are only read when count says valid
  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/psum_readout_ctrl.sv
// Streams a contiguous address range out of the partial-sum SRAM.
// Ports: clk, reset (async, active high); start/base_addr/length launch a
//        transfer; busy/done report progress; pmem_cen/pmem_wen/pmem_addr drive
//        the SRAM instruction fields; sfp_out is the SRAM read data (valid the
//        cycle after a read is presented); out_data/out_valid/out_ready form
//        the downstream valid/ready stream.
// Data path: a registered output stage backed by a 2-entry skid FIFO. Reads
// are issued only when every word already in flight has guaranteed space.
module psum_readout_ctrl
  import psum_readout_ctrl_pkg::*;
#(
  parameter int unsigned psum_bw = 16,
  parameter int unsigned col     = 8,
  parameter int unsigned addr_bw = PMEM_ADDR_BW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [addr_bw-1:0]     base_addr,
  input  logic [addr_bw:0]       length,
  output logic                   busy,
  output logic                   done,
  output logic                   pmem_cen,
  output logic                   pmem_wen,
  output logic [addr_bw-1:0]     pmem_addr,
  input  logic [col*psum_bw-1:0] sfp_out,
  output logic [col*psum_bw-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready
);

  localparam int unsigned DW      = col * psum_bw;
  localparam int unsigned CNT_BW  = addr_bw + 1;
  localparam int unsigned PEND_BW = RD_LAT + 1;

  state_t              state;
  state_t              state_next;
  logic [addr_bw-1:0]  rd_addr;
  logic [CNT_BW-1:0]   issue_cnt;
  logic [CNT_BW-1:0]   ret_cnt;
  // pend[0]: read presented to SRAM this cycle; pend[RD_LAT]: sfp_out valid now
  logic [PEND_BW-1:0]  pend;

  logic                issue_c;
  logic                load_c;
  logic                pop_c;
  logic                out_free_c;
  logic                push_in_c;
  logic                load_from_skid_c;
  logic                load_from_sfp_c;
  logic                skid_push_c;
  logic [3:0]          inflight_c;
  logic                credit_ok_c;

  logic [DW-1:0]       skid_head;
  logic [1:0]          skid_count;
  logic                skid_full;
  logic                skid_empty;

  assign pop_c      = out_valid & out_ready;
  assign out_free_c = ~out_valid | out_ready;
  assign push_in_c  = pend[RD_LAT];

  // Output register refills from the skid head first to keep word order
  assign load_from_skid_c = out_free_c & ~skid_empty;
  assign load_from_sfp_c  = out_free_c & skid_empty & push_in_c;
  assign skid_push_c      = push_in_c & ~load_from_sfp_c & (~skid_full | load_from_skid_c);

  // Words held or in flight, plus this issue, must fit output stage + skid (3)
  assign inflight_c  = 4'(out_valid) + 4'(skid_count) + 4'($countones(pend));
  assign credit_ok_c = (inflight_c + 4'd1) <= (4'd3 + 4'(pop_c));

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next state and issue decision
  always_comb begin
    state_next = state;
    issue_c    = 1'b0;
    load_c     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_c     = 1'b1;
          state_next = (length == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (issue_cnt != '0 && credit_ok_c) issue_c = 1'b1;
        if (issue_cnt == '0 || (issue_cnt == CNT_BW'(1) && issue_c)) state_next = DRAIN;
      end
      DRAIN: begin
        if (ret_cnt == '0 || (ret_cnt == CNT_BW'(1) && pop_c)) state_next = FIN;
      end
      FIN: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status, SRAM command and transfer counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      pmem_cen  <= 1'b1;
      pmem_wen  <= 1'b1;
      pmem_addr <= '0;
      rd_addr   <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      pend      <= '0;
    end else begin
      busy     <= (state_next != IDLE);
      done     <= (state_next == FIN);
      pmem_cen <= ~issue_c;
      pmem_wen <= 1'b1;
      pend     <= {pend[PEND_BW-2:0], issue_c};
      if (issue_c) pmem_addr <= rd_addr;
      if (load_c) begin
        rd_addr   <= base_addr;
        issue_cnt <= length;
        ret_cnt   <= length;
      end else begin
        if (issue_c) begin
          rd_addr   <= rd_addr + addr_bw'(1);
          issue_cnt <= issue_cnt - CNT_BW'(1);
        end
        if (pop_c && ret_cnt != '0) ret_cnt <= ret_cnt - CNT_BW'(1);
      end
    end
  end

  // Output stage: holds the head word stable while the consumer stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (out_free_c) begin
      out_valid <= load_from_skid_c | load_from_sfp_c;
      if (load_from_skid_c)     out_data <= skid_head;
      else if (load_from_sfp_c) out_data <= sfp_out;
    end
  end

  psum_skid_fifo #(
    .width (DW)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .push    (skid_push_c),
    .pop     (load_from_skid_c),
    .data_in (sfp_out),
    .head_c  (skid_head),
    .count   (skid_count),
    .full_c  (skid_full),
    .empty_c (skid_empty)
  );

endmodule

// File: tb/tb_psum_readout_ctrl.sv
// Bench for psum_readout_ctrl: SRAM model preloaded with word i = {8{16'(i+100)}},
// a table of transfers with per-cycle ready patterns, plus reset sequences.
module tb_psum_readout_ctrl;

  localparam int unsigned DW = 128;
  localparam int unsigned AW = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic          pmem_cen;
  logic          pmem_wen;
  logic [AW-1:0] pmem_addr;
  logic [DW-1:0] sfp_out;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;

  logic [DW-1:0] mem [2048];

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int          base;
    int          len;
    logic [31:0] rdy;       // bit k = out_ready driven for edge k+1
    int          exp_done;  // done edge relative to start edge, -1 = not fixed
    int          restart;   // pulse a second start while busy
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  // SRAM model: read presented while cen low appears on sfp_out next cycle
  always @(posedge clk) begin
    if (!pmem_cen) sfp_out <= mem[pmem_addr];
    else           sfp_out <= {8{16'hDEAD}};
  end

  psum_readout_ctrl u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .pmem_cen  (pmem_cen),
    .pmem_wen  (pmem_wen),
    .pmem_addr (pmem_addr),
    .sfp_out   (sfp_out),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int v, output int first_addr, output int last_addr);
    vec_t          vb;
    int            addrs[$];
    logic [DW-1:0] got[$];
    int            done_cnt, done_at, first_iss, last_iss, first_vld;
    int            stab_bad, ovf, wen_bad, nbad, budget;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    vb = vecs[v];
    done_cnt = 0; done_at = -1; first_iss = -1; last_iss = -1; first_vld = -1;
    stab_bad = 0; ovf = 0; wen_bad = 0; prev_stall = 1'b0; prev_data = '0;
    budget = 4 * vb.len + 60;
    @(negedge clk);
    base_addr = AW'(vb.base);
    length    = 12'(vb.len);
    out_ready = 1'b1;
    start     = 1'b1;
    @(posedge clk);                   // edge 0
    #1 start = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d busy_after_start", v), 128'(busy), 128'(1));
    for (int k = 0; k < budget; k++) begin
      if (vb.restart != 0 && k == 2) begin
        base_addr = AW'(500);
        length    = 12'(3);
        start     = 1'b1;
      end
      if (vb.restart != 0 && k == 3) start = 1'b0;
      if (!pmem_cen) begin
        addrs.push_back(int'(pmem_addr));
        if (first_iss < 0) first_iss = k;
        last_iss = k;
      end
      if (done) begin
        done_cnt++;
        done_at = k;
      end
      if (pmem_wen !== 1'b1) wen_bad++;
      if (u_dut.u_skid.count > 2'd2) ovf++;
      if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) stab_bad++;
      if (out_valid && first_vld < 0) first_vld = k;
      out_ready = vb.rdy[k % 32];
      if (out_valid && out_ready) got.push_back(out_data);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      if (done_cnt > 0 && k >= done_at + 4) break;
      @(negedge clk);
    end
    check($sformatf("v%0d addr_count", v), 128'(addrs.size()), 128'(vb.len));
    nbad = 0;
    for (int i = 0; i < addrs.size() && i < vb.len; i++)
      if (addrs[i] != (vb.base + i) % 2048) nbad++;
    check($sformatf("v%0d addr_seq_errs", v), 128'(nbad), 128'(0));
    check($sformatf("v%0d data_count", v), 128'(got.size()), 128'(vb.len));
    nbad = 0;
    for (int i = 0; i < got.size() && i < vb.len; i++)
      if (got[i] !== mem[(vb.base + i) % 2048]) nbad++;
    check($sformatf("v%0d data_seq_errs", v), 128'(nbad), 128'(0));
    check($sformatf("v%0d done_count", v), 128'(done_cnt), 128'(1));
    if (vb.exp_done >= 0) begin
      check($sformatf("v%0d done_edge", v), 128'(done_at), 128'(vb.exp_done));
      if (vb.len > 0) begin
        check($sformatf("v%0d first_issue_edge", v), 128'(first_iss), 128'(1));
        check($sformatf("v%0d last_issue_edge", v), 128'(last_iss), 128'(vb.len));
        check($sformatf("v%0d first_valid_edge", v), 128'(first_vld), 128'(3));
      end
    end
    check($sformatf("v%0d stall_stability_errs", v), 128'(stab_bad), 128'(0));
    check($sformatf("v%0d skid_overflow", v), 128'(ovf), 128'(0));
    check($sformatf("v%0d wen_errs", v), 128'(wen_bad), 128'(0));
    check($sformatf("v%0d busy_at_end", v), 128'(busy), 128'(0));
    first_addr = (addrs.size() > 0) ? addrs[0] : -1;
    last_addr  = (addrs.size() > 0) ? addrs[addrs.size()-1] : -1;
  endtask

  initial begin
    int fa, la;
    for (int i = 0; i < 2048; i++) mem[i] = {8{16'(i + 100)}};

    vecs[0] = '{base: 0,    len: 4,    rdy: 32'hFFFF_FFFF, exp_done: 7,    restart: 0};
    vecs[1] = '{base: 2046, len: 4,    rdy: 32'hFFFF_FFFF, exp_done: 7,    restart: 0};
    vecs[2] = '{base: 10,   len: 8,    rdy: 32'hB3D5_7A69, exp_done: -1,   restart: 0};
    vecs[3] = '{base: 77,   len: 0,    rdy: 32'hFFFF_FFFF, exp_done: 0,    restart: 0};
    vecs[4] = '{base: 100,  len: 6,    rdy: 32'hFFFF_FFFF, exp_done: 9,    restart: 1};
    vecs[5] = '{base: 2040, len: 16,   rdy: 32'h0924_9249, exp_done: -1,   restart: 0};
    vecs[6] = '{base: 5,    len: 2048, rdy: 32'hFFFF_FFFF, exp_done: 2051, restart: 0};

    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
    #1;
    check("rst busy",      128'(busy),      128'(0));
    check("rst done",      128'(done),      128'(0));
    check("rst pmem_cen",  128'(pmem_cen),  128'(1));
    check("rst pmem_wen",  128'(pmem_wen),  128'(1));
    check("rst pmem_addr", 128'(pmem_addr), 128'(0));
    check("rst out_valid", 128'(out_valid), 128'(0));
    check("rst out_data",  128'(out_data),  128'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset in the middle of a long transfer
    @(negedge clk);
    base_addr = '0; length = 12'(20); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid busy_before_reset",  128'(busy),      128'(1));
    check("mid valid_before_reset", 128'(out_valid), 128'(1));
    #2 reset = 1'b1;
    #1;
    check("mid pmem_cen",  128'(pmem_cen),  128'(1));
    check("mid out_valid", 128'(out_valid), 128'(0));
    check("mid busy",      128'(busy),      128'(0));
    check("mid done",      128'(done),      128'(0));
    @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      run_vec(v, fa, la);
      if (v == 1) begin
        check("wrap first_addr", 128'(fa), 128'(2046));
        check("wrap last_addr",  128'(la), 128'(1));
      end
      if (v == 6) begin
        check("full first_addr", 128'(fa), 128'(5));
        check("full last_addr",  128'(la), 128'(4));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
